// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM receive demultiplexer.
// Holds the lock-state encoding, error-counter width and slice-offset helper.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int ERR_CNT_W = 8;

  function automatic int slice_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for the TDM demux: steps 0..NCH-1 and wraps to 0.
// Ports: clk, reset_n, load1 (resync to slot 1), step, idx, is_last.
module tdm_slot_ctr #(
  parameter int NCH = 4,
  parameter int IW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load1,
  input  logic          step,
  output logic [IW-1:0] idx,
  output logic          is_last
);

  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  assign is_last = (idx == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (load1) begin
      idx <= IW'(1);
    end else if (step) begin
      // explicit wrap keeps idx inside 0..NCH-1 for non power-of-two NCH
      idx <= is_last ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demux: writes interleaved words into per-channel registers.
// Ports: clk, reset_n, din/din_valid/frame in; ch_data, ch_valid,
// frame_done, locked, sync_err, err_cnt out.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int IW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [W-1:0]         din,
  input  logic                 din_valid,
  input  logic                 frame,
  output logic [NCH*W-1:0]     ch_data,
  output logic [NCH-1:0]       ch_valid,
  output logic                 frame_done,
  output logic                 locked,
  output logic                 sync_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_t        state;
  logic [IW-1:0] idx;
  logic          is_last;
  logic          in_lock;
  logic          at_zero;
  logic          load1;
  logic          step;
  logic          early;
  logic          missing;

  always_comb begin
    in_lock = (state == LOCK);
    at_zero = (idx == '0);
    // any qualified frame word becomes channel 0 and resyncs to slot 1
    load1   = din_valid && frame;
    early   = din_valid && frame && in_lock && !at_zero;
    missing = din_valid && !frame && in_lock && at_zero;
    step    = din_valid && !frame && in_lock && !at_zero;
  end

  tdm_slot_ctr #(
    .NCH (NCH),
    .IW  (IW)
  ) u_slot_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .load1   (load1),
    .step    (step),
    .idx     (idx),
    .is_last (is_last)
  );

  assign locked = in_lock;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HUNT;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (early || missing) begin
        sync_err <= 1'b1;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
      unique case (1'b1)
        load1: begin
          ch_data[W-1:0] <= din;
          ch_valid       <= NCH'(1);
          state          <= LOCK;
        end
        missing: begin
          state <= HUNT;
        end
        step: begin
          ch_data[slice_off(int'(idx), W) +: W] <= din;
          ch_valid   <= NCH'(1) << idx;
          frame_done <= is_last;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: receives one word stream in which NCH channels are interleaved, and writes each word back into its own per-channel register.
- Receive-side counterpart of the team's 2:1 select mux: a frame-sync flag marks channel 0, and a channel counter steps through the slots.
- Sits between a serial/TDM link front-end and per-channel consumers.
- Outputs include per-channel strobes, a frame-complete pulse, sync-error detection and a saturating error counter.

Parameters:
- NCH, 4, number of interleaved channels; legal range 2..16.
- W, 8, data word width in bits.
- IW, $clog2(NCH), channel index width (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset (asserts immediately, releases synchronously to clk).
- din  input  W  incoming time-multiplexed word.
- din_valid  input  1  din is a real slot word this cycle.
- frame  input  1  qualified by din_valid; marks the channel-0 word.
- ch_data  output  NCH*W  per-channel holding registers; channel k occupies bits [k*W +: W].
- ch_valid  output  NCH  one-cycle strobe; bit k=1 when ch_data channel k was updated on the last edge.
- frame_done  output  1  one-cycle pulse coincident with the ch_valid[NCH-1] strobe.
- locked  output  1  1 while the state machine is in LOCK.
- sync_err  output  1  one-cycle pulse on a detected frame misalignment.
- err_cnt  output  8  count of sync_err events, saturating at 255.

Behaviour:
- Reset (reset_n=0, async): ch_data=0, ch_valid=0, frame_done=0, sync_err=0, err_cnt=0, locked=0, idx=0, state=HUNT.
- Latency: a word accepted on edge k updates ch_data and pulses ch_valid/frame_done after that same edge (visible for one cycle). Pipeline depth is 1.
- din_valid=0 cycles:
  - No state, idx or ch_data change.
  - All strobes (ch_valid, frame_done, sync_err) are 0.
  - frame is ignored.
- HUNT state:
  - din_valid && !frame: word discarded, no strobes.
  - din_valid && frame: ch0<=din, ch_valid[0] pulses, idx<=1, state<=LOCK.
- LOCK state, din_valid=1, decided in this priority:
  1. frame=1 and idx!=0 (early frame): sync_err pulses, err_cnt++. The word is taken as the new channel 0: ch0<=din, ch_valid[0] pulses, idx<=1, stay in LOCK. Channels idx..NCH-1 keep their stale contents; frame_done does not pulse.
  2. frame=0 and idx==0 (missing frame): sync_err pulses, err_cnt++, word discarded, state<=HUNT, locked falls next cycle.
  3. Otherwise: ch[idx]<=din, ch_valid[idx] pulses.
     - If idx==NCH-1: frame_done pulses and idx<=0.
     - Else idx<=idx+1.
- idx wraps only via the idx==NCH-1 rule; it never exceeds NCH-1 (matters when NCH is not a power of two).
- err_cnt holds at 255 once reached; sync_err still pulses.
- Reset asserted mid-frame: all state clears immediately. After release, the block hunts for the next frame; partial frames are never completed.
- At most one ch_valid bit is high in any cycle.

Decomposition:
- Package tdm_pkg:
  - HUNT/LOCK state encoding (1-bit enum).
  - ERR_CNT_W=8 constant.
  - Helper function for channel slice offset (k*W).
- One natural sub-module: tdm_slot_ctr. It holds the idx counter with wrap at NCH-1, and outputs an is_last flag plus a load-to-1 input used for resync.
- ch_data registers and the state machine stay in tdm_demux.

Test Plan:
- Clean frames: NCH=4, W=8. Stream 0x11(frame),0x22,0x33,0x44 twice, din_valid held high.
  - ch_valid sequence 0001,0010,0100,1000 repeated; frame_done high on the 0x44 cycles.
  - Final ch_data = 0x44332211; locked=1 from the cycle after 0x11; err_cnt=0.
- Gapped input: same frame with din_valid=0 for 3 cycles between 0x22 and 0x33.
  - No strobes in the gap, idx holds.
  - Result identical to the clean case, frame_done once.
- Early frame: 0xA0(frame),0xA1,0xB0(frame),0xB1,0xB2,0xB3.
  - sync_err pulses on the 0xB0 cycle, err_cnt=1.
  - ch0=0xB0, and frame_done fires on 0xB3.
- Missing frame: complete a frame, then send 0x55 with frame=0.
  - sync_err pulses, locked drops next cycle, ch0 unchanged.
  - Subsequent non-frame words are ignored until the next frame word relocks.
- Reset mid-frame: drive reset_n low asynchronously (between edges) after 0x11,0x22.
  - All outputs read 0 immediately; the next non-frame words after release cause no strobes.
- Saturation: force 260 early-frame errors; err_cnt reads 255 and sync_err still pulses on each error.
